integral_window_stream: RTL and testbench
=========================================

Name: integral_window_stream

Overview:
- Next-generation streaming sliding-window integral buffer for the face-detection front end. Generalises the binary-pixel version to multi-bit pixels.
- Generates its own raster coordinates, so the external Addr port is gone.
- Uses valid/ready handshakes on input and output, with backpressure.
- Flags only complete windows and tags each one with its image position. Sits between the pixel source and the classifier stage.

Parameters:
- ImageWidth, 640, pixels per row (>= WindowSize).
- ImageHeight, 480, rows per frame (>= WindowSize).
- WindowSize, 20, window edge n (square n x n).
- PixelWidth, 1, bits per pixel P (1..8).
- Derived: IntegralWidth W = clog2(n*n*(2^P-1)+1); XW = clog2(ImageWidth); YW = clog2(ImageHeight).

Ports:
- Clock  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous active-low reset.
- Clear  in  1  synchronous frame restart.
- PixelData  in  P  raster-order pixel.
- PixelValid  in  1  PixelData valid.
- PixelReady  out  1  block accepts pixel this cycle.
- WindowValid  out  1  IntegralPacked/WinX/WinY valid.
- WindowReady  in  1  downstream consumes window.
- IntegralPacked  out  W*n*n  element (n*y+x) at bits [W*(n*y+x)+W-1 : W*(n*y+x)].
- WinX  out  XW  window left column.
- WinY  out  YW  window top row.
- FrameDone  out  1  one-cycle pulse on acceptance of the last pixel of the frame.
- SqSum  out  2*P+clog2(n*n+1)  window sum of squares (see Optional Feature).

Behaviour:
- Reset (Reset_n low, asynchronous): counters, window registers, output registers, WindowValid, FrameDone and SqSum all go to 0. Line-buffer RAM contents are don't-care.
- Accept = PixelValid && PixelReady.
- Advance = !WindowValid || WindowReady. PixelReady = Advance, purely combinational; Reset_n low forces PixelReady = 0.
- Counters col/row start at 0.
  - On Accept, col increments. At ImageWidth-1, col wraps to 0 and row increments.
  - At (ImageWidth-1, ImageHeight-1), both wrap to 0 and FrameDone pulses on the next cycle.
- Line buffer: n-1 rows x ImageWidth x P, addressed by col. On Accept it supplies the n-1 pixels above the current pixel and stores the current one. Row ring rotates at each row wrap.
- Stage 1, window register (n x n pixels), updates on Accept: shifts one column left; the new right column = {line-buffer column, PixelData}. Row 0 is top/oldest; column 0 is leftmost. A flag S1 = (row >= n-1 && col >= n-1) is registered with it, using the coordinates of the accepted pixel. A window never straddles a row boundary.
- Stage 2, output, loads on Advance:
  - WindowValid <= S1 && (stage 1 accepted on the previous Advance).
  - IntegralPacked element (y,x) <= sum of window[r][c] for r<=y, c<=x.
  - WinX <= col-(n-1), WinY <= row-(n-1) of the completing pixel.
  - Outputs are held unchanged while WindowValid && !WindowReady.
- Latency: WindowValid rises 2 cycles after the accepting edge, when unstalled. Throughput is 1 window/cycle.
- Arithmetic is unsigned. W bits hold the exact maximum, so no saturation or wrap is possible.
- Windows per frame = (ImageWidth-n+1)*(ImageHeight-n+1).
- Clear (synchronous) has priority over Accept: counters, S1, WindowValid and FrameDone go to 0 next cycle; the pixel offered that cycle is dropped. Window/line contents need no clearing, because validity gating forces n fresh rows.
- Reset_n asserted mid-frame: immediate return to the reset state; the next frame starts at (0,0).
- Simultaneous WindowReady and a new completing window: the old window retires and the new one loads on the same edge, with no bubble.

Optional Feature:
- Macro INTEGRAL_SQUARE_SUM_EN.
- Defined: stage 2 also loads SqSum = sum of window[r][c]^2 over the full window, aligned with and held like IntegralPacked; it is used for variance normalisation.
- Undefined: SqSum is tied to 0, no multipliers are synthesised, and the port is still present.

Test Plan:
- Parameters for all scenarios: ImageWidth=8, ImageHeight=6, WindowSize=3, PixelWidth=4.
- All pixels 1, WindowReady=1, PixelValid=1 -> first WindowValid 2 cycles after the 19th accept, WinX=0 WinY=0, element(y,x)=(x+1)(y+1), element(2,2)=9. Exactly 24 windows per frame, FrameDone pulses once after the 48th accept.
- Pixel = column index -> window WinX=5: element(2,2)=3*(5+6+7)=54, element(0,0)=5. No window is flagged for col<2 or row<2.
- All pixels 15 -> element(2,2)=135 fits W=8. With INTEGRAL_SQUARE_SUM_EN, SqSum=2025; without it, SqSum=0.
- WindowReady held low 5 cycles while windows pending -> PixelReady low the same cycles, outputs bit-stable. After release, all 24 windows arrive in raster order with none lost or duplicated.
- Reset_n low at pixel 30 -> WindowValid/PixelReady 0 immediately. After release, a fresh frame yields its first window after 19 accepts with WinX=0 WinY=0.
- Clear asserted together with PixelValid at pixel 25 -> that pixel is dropped, WindowValid 0 next cycle, and counting restarts at (0,0).

Source files
------------

// File: rtl/integral_window_stream.sv
// rtl/integral_window_stream.sv - streaming n x n sliding-window integral buffer with valid/ready handshakes (optional INTEGRAL_SQUARE_SUM_EN adds window sum of squares)
module integral_window_stream #(
    parameter int ImageWidth  = 640,
    parameter int ImageHeight = 480,
    parameter int WindowSize  = 20,
    parameter int PixelWidth  = 1,
    localparam int N   = WindowSize,
    localparam int P   = PixelWidth,
    localparam int W   = $clog2(N * N * ((1 << P) - 1) + 1),
    localparam int XW  = $clog2(ImageWidth),
    localparam int YW  = $clog2(ImageHeight),
    localparam int SQW = 2 * P + $clog2(N * N + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic [P-1:0]         i_pixel_data,
    input  logic                 i_pixel_valid,
    output logic                 o_pixel_ready,
    output logic                 o_window_valid,
    input  logic                 i_window_ready,
    output logic [W*N*N-1:0]     o_integral_packed,
    output logic [XW-1:0]        o_win_x,
    output logic [YW-1:0]        o_win_y,
    output logic                 o_frame_done,
    output logic [SQW-1:0]       o_sq_sum
);

    // Line-buffer word per column: the n-1 pixels above the current row, oldest (top) in the LSBs.
    localparam int LBW = (N - 1) * P;
    localparam logic [XW-1:0] ColLast = XW'(ImageWidth - 1);
    localparam logic [YW-1:0] RowLast = YW'(ImageHeight - 1);
    localparam logic [XW-1:0] ColEdge = XW'(N - 1);
    localparam logic [YW-1:0] RowEdge = YW'(N - 1);

    logic [XW-1:0]   r_col;
    logic [YW-1:0]   r_row;
    logic            r_frame_done;
    logic [LBW-1:0]  r_line_mem [ImageWidth];
    logic [P-1:0]    r_win [N][N];
    logic            r_s1_fresh;
    logic [XW-1:0]   r_s1_x;
    logic [YW-1:0]   r_s1_y;
    logic            r_window_valid;
    logic [W*N*N-1:0] r_integral;
    logic [XW-1:0]   r_win_x;
    logic [YW-1:0]   r_win_y;

    logic            w_advance;
    logic            w_pixel_ready;
    logic            w_accept;
    logic            w_col_last;
    logic            w_row_last;
    logic            w_complete;
    logic [LBW-1:0]  w_line_rd;
    logic [LBW-1:0]  w_line_wr;
    logic [P-1:0]    w_new_col [N];
    logic [W-1:0]    w_row_acc;
    logic [W-1:0]    w_col_acc [N];
    logic [W*N*N-1:0] w_integral;

    // Both stages move together: stage 1 can only take a pixel when stage 2 can take its result.
    assign w_advance     = !r_window_valid || i_window_ready;
    assign w_pixel_ready = i_rst_n && w_advance;
    assign w_accept      = i_pixel_valid && w_pixel_ready && !i_clear;
    assign w_col_last    = (r_col == ColLast);
    assign w_row_last    = (r_row == RowLast);
    assign w_complete    = (r_col >= ColEdge) && (r_row >= RowEdge);
    assign w_line_rd     = r_line_mem[r_col];

    // Storing the current pixel drops the oldest row of this column's history.
    generate
        if (N > 2) begin : g_line_shift
            assign w_line_wr = {i_pixel_data, w_line_rd[LBW-1:P]};
        end else begin : g_line_single
            assign w_line_wr = i_pixel_data;
        end
    endgenerate

    // Incoming right-hand window column: buffered rows on top, live pixel at the bottom.
    always_comb begin
        for (int r = 0; r < N - 1; r++) begin
            w_new_col[r] = w_line_rd[r*P +: P];
        end
        w_new_col[N-1] = i_pixel_data;
    end

    // Raster position of the next pixel to accept, plus the end-of-frame pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
        end else if (i_clear) begin
            r_col        <= '0;
            r_row        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_accept && w_col_last && w_row_last;
            if (w_accept) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    // Line-buffer RAM; contents are never reset since windows need n fresh rows before they count.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_line_mem[r_col] <= w_line_wr;
        end
    end

    // Stage 1: slide the window one column left on every accepted pixel and note whether it completes a window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    r_win[r][c] <= '0;
                end
            end
            r_s1_fresh <= 1'b0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
        end else begin
            if (w_accept) begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N - 1; c++) begin
                        r_win[r][c] <= r_win[r][c+1];
                    end
                    r_win[r][N-1] <= w_new_col[r];
                end
                r_s1_x <= r_col - ColEdge;
                r_s1_y <= r_row - RowEdge;
            end
            if (i_clear) begin
                r_s1_fresh <= 1'b0;
            end else if (w_advance) begin
                r_s1_fresh <= w_accept && w_complete;
            end
        end
    end

    // Integral image of the window: running row prefix added onto the column totals of the rows above.
    always_comb begin
        w_integral = '0;
        w_row_acc  = '0;
        for (int c = 0; c < N; c++) begin
            w_col_acc[c] = '0;
        end
        for (int y = 0; y < N; y++) begin
            w_row_acc = '0;
            for (int x = 0; x < N; x++) begin
                w_row_acc    = w_row_acc + W'(r_win[y][x]);
                w_col_acc[x] = w_col_acc[x] + w_row_acc;
                w_integral[W*(N*y+x) +: W] = w_col_acc[x];
            end
        end
    end

`ifdef INTEGRAL_SQUARE_SUM_EN
    logic [2*P-1:0]  w_pix_ext;
    logic [SQW-1:0]  w_sq_sum;
    logic [SQW-1:0]  r_sq_sum;

    // Sum of squared pixels over the whole window, used downstream for variance normalisation.
    always_comb begin
        w_sq_sum  = '0;
        w_pix_ext = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                w_pix_ext = {{P{1'b0}}, r_win[r][c]};
                w_sq_sum  = w_sq_sum + SQW'(w_pix_ext * w_pix_ext);
            end
        end
    end

    // Square sum rides alongside the integral image and is held under the same stall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sq_sum <= '0;
        end else if (!i_clear && w_advance && r_s1_fresh) begin
            r_sq_sum <= w_sq_sum;
        end
    end

    assign o_sq_sum = r_sq_sum;
`else
    assign o_sq_sum = '0;
`endif

    // Stage 2: output register, frozen while the consumer holds off a presented window.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_window_valid <= 1'b0;
            r_integral     <= '0;
            r_win_x        <= '0;
            r_win_y        <= '0;
        end else if (i_clear) begin
            r_window_valid <= 1'b0;
        end else if (w_advance) begin
            r_window_valid <= r_s1_fresh;
            if (r_s1_fresh) begin
                r_integral <= w_integral;
                r_win_x    <= r_s1_x;
                r_win_y    <= r_s1_y;
            end
        end
    end

    assign o_pixel_ready     = w_pixel_ready;
    assign o_window_valid    = r_window_valid;
    assign o_integral_packed = r_integral;
    assign o_win_x           = r_win_x;
    assign o_win_y           = r_win_y;
    assign o_frame_done      = r_frame_done;

endmodule

// File: tb/tb_integral_window_stream.sv
// tb/tb_integral_window_stream.sv - self-checking bench for integral_window_stream
`timescale 1ns/1ps
module tb_integral_window_stream;
    localparam int IW = 8;
    localparam int IH = 6;
    localparam int N = 3;
    localparam int P = 4;
    localparam int W = 8;
    localparam int XW = 3;
    localparam int YW = 3;
    localparam int SQW = 12;
`ifdef INTEGRAL_SQUARE_SUM_EN
    localparam bit SQ_EN = 1'b1;
`else
    localparam bit SQ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic [P-1:0] pdata;
    logic pvalid;
    logic pready;
    logic wvalid;
    logic wready;
    logic [W*N*N-1:0] ipk;
    logic [XW-1:0] wx;
    logic [YW-1:0] wy;
    logic fdone;
    logic [SQW-1:0] sq;

    integral_window_stream #(
        .ImageWidth(IW), .ImageHeight(IH), .WindowSize(N), .PixelWidth(P)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear),
        .i_pixel_data(pdata), .i_pixel_valid(pvalid), .o_pixel_ready(pready),
        .o_window_valid(wvalid), .i_window_ready(wready),
        .o_integral_packed(ipk), .o_win_x(wx), .o_win_y(wy),
        .o_frame_done(fdone), .o_sq_sum(sq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int x;
        int y;
        int e[N*N];
        int sq;
        int acc_cyc;
    } win_t;

    win_t q[$];
    int img[IH][IW];
    int mcol = 0, mrow = 0, cyc = 0, acc_cnt = 0, acc19_cyc = 0;
    int n_windows = 0, fd_count = 0;
    int first_x = -1, first_y = -1, first_e22 = -1, first_e00 = -1, first_sq = -1, first_cyc = 0;
    int x5_e22 = -1, x5_e00 = -1;
    bit got_x5 = 0;
    bit lat_en = 0, exp_fd = 0, prev_hold = 0, prev_clear = 0;
    logic [W*N*N-1:0] held_ipk;
    int held_x, held_y, held_sq;

    function automatic void frame_reset();
        q.delete();
        mcol = 0; mrow = 0; acc_cnt = 0; n_windows = 0; fd_count = 0; got_x5 = 0;
    endfunction

    // Reference model and per-cycle compare, sampled on the falling edge.
    always @(negedge clk) begin
        win_t e;
        win_t n;
        bit acc;
        int s;
        cyc++;
        if (!rst_n) begin
            frame_reset();
            prev_hold = 0; exp_fd = 0; prev_clear = 0;
        end else begin
            check("frame_done", fdone, exp_fd);
            if (prev_hold && !prev_clear) begin
                check("hold_valid", wvalid, 1);
                check("hold_integral", (ipk === held_ipk), 1);
                check("hold_x", wx, held_x);
                check("hold_y", wy, held_y);
                check("hold_sq", sq, held_sq);
            end
            if (wvalid && wready) begin
                check("window_expected", (q.size() > 0), 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("win_x", wx, e.x);
                    check("win_y", wy, e.y);
                    for (int i = 0; i < N*N; i++) begin
                        check($sformatf("elem%0d", i), ipk[W*i +: W], e.e[i]);
                    end
                    check("sq_sum", sq, e.sq);
                    if (lat_en) check("latency", cyc - e.acc_cyc, 2);
                    n_windows++;
                    if (n_windows == 1) begin
                        first_x = wx; first_y = wy; first_cyc = cyc; first_sq = sq;
                        first_e22 = ipk[W*8 +: W]; first_e00 = ipk[0 +: W];
                    end
                    if (wx == 5 && !got_x5) begin
                        got_x5 = 1; x5_e22 = ipk[W*8 +: W]; x5_e00 = ipk[0 +: W];
                    end
                end
            end
            if (fdone) fd_count++;
            prev_hold = wvalid && !wready;
            held_ipk = ipk; held_x = wx; held_y = wy; held_sq = sq;
            prev_clear = clear;
            acc = pvalid && pready && !clear;
            exp_fd = acc && (mcol == IW-1) && (mrow == IH-1);
            if (clear) begin
                frame_reset();
            end else if (acc) begin
                img[mrow][mcol] = pdata;
                acc_cnt++;
                if (acc_cnt == 19) acc19_cyc = cyc;
                if (mrow >= N-1 && mcol >= N-1) begin
                    n.x = mcol - (N-1);
                    n.y = mrow - (N-1);
                    n.sq = 0;
                    n.acc_cyc = cyc;
                    for (int y = 0; y < N; y++) begin
                        for (int x = 0; x < N; x++) begin
                            s = 0;
                            for (int r = 0; r <= y; r++)
                                for (int c = 0; c <= x; c++)
                                    s += img[mrow-(N-1)+r][mcol-(N-1)+c];
                            n.e[N*y+x] = s;
                            if (SQ_EN) n.sq += img[mrow-(N-1)+y][mcol-(N-1)+x] * img[mrow-(N-1)+y][mcol-(N-1)+x];
                        end
                    end
                    q.push_back(n);
                end
                if (mcol == IW-1) begin
                    mcol = 0;
                    mrow = (mrow == IH-1) ? 0 : mrow + 1;
                end else begin
                    mcol++;
                end
            end
        end
    end

    int dcol, drow;

    function automatic logic [P-1:0] pix(input int mode, input int c, input int r);
        case (mode)
            0: return 4'd1;
            1: return P'(c);
            2: return 4'd15;
            default: return P'((c*3 + r*5 + 1) % 16);
        endcase
    endfunction

    // ev: 0 none, 1 reset while offering pixel 30, 2 clear while offering pixel 25.
    task automatic drive(input int count, input int mode, input bit do_stall, input int ev);
        int done = 0;
        int guard = 0;
        int stall_left = 0;
        bit stalled_once = 0;
        bit acc;
        dcol = 0; drow = 0;
        while (done < count && guard < 1000) begin
            guard++;
            if (do_stall && !stalled_once && dcol == 6 && drow == 3) begin
                stalled_once = 1; stall_left = 5;
            end
            wready = (stall_left == 0);
            pvalid = 1'b1;
            pdata = pix(mode, dcol, drow);
            if (ev == 1 && done == 29) begin
                check("pre_reset_wvalid", wvalid, 1);
                rst_n = 1'b0;
                #1;
                check("reset_wvalid", wvalid, 0);
                check("reset_pready", pready, 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                ev = 0; done = 0; dcol = 0; drow = 0;
                continue;
            end
            if (ev == 2 && done == 24) begin
                check("pre_clear_wvalid", wvalid, 1);
                clear = 1'b1;
                @(posedge clk); #1;
                clear = 1'b0;
                check("clear_wvalid", wvalid, 0);
                ev = 0; done = 0; dcol = 0; drow = 0;
                continue;
            end
            @(negedge clk);
            acc = pready;
            if (stall_left > 0) begin
                check("stall_pready", pready, 0);
                check("stall_wvalid", wvalid, 1);
            end
            @(posedge clk); #1;
            if (stall_left > 0) stall_left--;
            if (acc) begin
                done++;
                if (dcol == IW-1) begin
                    dcol = 0;
                    drow = (drow == IH-1) ? 0 : drow + 1;
                end else begin
                    dcol++;
                end
            end
        end
        pvalid = 1'b0;
        wready = 1'b1;
        check("drive_complete", done, count);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clear = 1'b0; pvalid = 1'b0; wready = 1'b1; pdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; pvalid = 1'b0; wready = 1'b1; pdata = '0;
        @(posedge clk); #1;
        check("rst_wvalid", wvalid, 0);
        check("rst_pready", pready, 0);
        check("rst_fdone", fdone, 0);
        check("rst_sq", sq, 0);
        check("rst_integral_zero", (ipk == '0), 1);
        check("rst_winxy", {wx, wy}, 0);

        // all ones
        do_reset(); lat_en = 1;
        drive(48, 0, 0, 0); drain();
        check("t1_windows", n_windows, 24);
        check("t1_frame_done_count", fd_count, 1);
        check("t1_queue_empty", q.size(), 0);
        check("t1_first_x", first_x, 0);
        check("t1_first_y", first_y, 0);
        check("t1_first_e22", first_e22, 9);
        check("t1_first_e00", first_e00, 1);
        check("t1_first_latency", first_cyc - acc19_cyc, 2);

        // pixel = column index
        do_reset();
        drive(48, 1, 0, 0); drain();
        check("t2_got_x5", got_x5, 1);
        check("t2_x5_e22", x5_e22, 54);
        check("t2_x5_e00", x5_e00, 5);
        check("t2_windows", n_windows, 24);

        // saturated pixels
        do_reset();
        drive(48, 2, 0, 0); drain();
        check("t3_e22", first_e22, 135);
        check("t3_sq", first_sq, SQ_EN ? 2025 : 0);

        // backpressure
        do_reset(); lat_en = 0;
        drive(48, 3, 1, 0); drain();
        check("t4_windows", n_windows, 24);
        check("t4_queue_empty", q.size(), 0);

        // reset mid-frame
        do_reset(); lat_en = 1;
        drive(48, 3, 0, 1); drain();
        check("t5_windows", n_windows, 24);
        check("t5_first_x", first_x, 0);
        check("t5_first_y", first_y, 0);
        check("t5_first_latency", first_cyc - acc19_cyc, 2);

        // clear mid-frame
        do_reset();
        drive(48, 3, 0, 2); drain();
        check("t6_windows", n_windows, 24);
        check("t6_frame_done_count", fd_count, 1);
        check("t6_first_x", first_x, 0);
        check("t6_first_y", first_y, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
